axi_lite_slave_fe: RTL and testbench

// - AXI4-Lite slave protocol front end. Terminates AW/W/B/AR/R handshakes from the PS interconnect.
// - Drives latched addr/data plus single-cycle slv_reg_wren/slv_reg_rden strobes into the range decoder.
// - Returns the decoder's registered S_AXI_RDATA on the R channel.
// - One outstanding write and one outstanding read. The two channels are fully independent.

---
 rtl/axi_lite_slave_fe_if.sv | 37 +++
 rtl/axi_lite_slave_fe.sv | 107 ++++++++++
 tb/tb_axi_lite_slave_fe.sv | 331 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_slave_fe_if.sv
// axi_lite_slave_fe_if: AXI4-Lite AW/W/B/AR/R bundle between the PS interconnect (master) and the slave front end.
interface axi_lite_slave_fe_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 12
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic                            S_AXI_AWVALID;
    logic                            S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                            S_AXI_WVALID;
    logic                            S_AXI_WREADY;
    logic [1:0]                      S_AXI_BRESP;
    logic                            S_AXI_BVALID;
    logic                            S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic                            S_AXI_ARVALID;
    logic                            S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]                      S_AXI_RRESP;
    logic                            S_AXI_RVALID;
    logic                            S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
               S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
               S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID, S_AXI_BREADY,
               S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
               S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/axi_lite_slave_fe.sv
// axi_lite_slave_fe: AXI4-Lite slave front end issuing single-cycle wren/rden strobes to a range decoder.
// Define AXI_SLVERR_EN to answer SLVERR for addresses whose addr[11:8] lies beyond C_NUM_RANGES.
module axi_lite_slave_fe #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 12,
    parameter int C_NUM_RANGES       = 5
) (
    input  logic                            S_AXI_ACLK,
    input  logic                            S_AXI_ARESETN,
    axi_lite_slave_fe_if.slave              s_axi,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]   dec_awaddr,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   dec_wdata,
    output logic [C_S_AXI_DATA_WIDTH/8-1:0] dec_wstrb,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]   dec_araddr,
    output logic                            slv_reg_wren,
    output logic                            slv_reg_rden,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   dec_rdata
);
`ifdef AXI_SLVERR_EN
    localparam logic SLVERR_EN = 1'b1;
`else
    localparam logic SLVERR_EN = 1'b0;
`endif
    localparam logic [3:0] NUM_RANGES = 4'(C_NUM_RANGES);

    typedef enum logic [1:0] {WR_IDLE, WR_STROBE, WR_RESP} wr_state_t;
    typedef enum logic [1:0] {RD_IDLE, RD_STROBE, RD_DATA} rd_state_t;

    wr_state_t wr_state, wr_next;
    rd_state_t rd_state, rd_next;
    logic      init_done;
    logic      aw_held, w_held;
    logic      aw_hs, w_hs, ar_hs;
    logic      wr_err, rd_err;

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN)
        if (!S_AXI_ARESETN) init_done <= 1'b0;
        else init_done <= 1'b1;

    assign s_axi.S_AXI_AWREADY = init_done & ~aw_held & (wr_state == WR_IDLE);
    assign s_axi.S_AXI_WREADY  = init_done & ~w_held & (wr_state == WR_IDLE);
    assign s_axi.S_AXI_ARREADY = init_done & (rd_state == RD_IDLE);
    assign aw_hs = s_axi.S_AXI_AWVALID & s_axi.S_AXI_AWREADY;
    assign w_hs  = s_axi.S_AXI_WVALID & s_axi.S_AXI_WREADY;
    assign ar_hs = s_axi.S_AXI_ARVALID & s_axi.S_AXI_ARREADY;
    assign wr_err = SLVERR_EN & (dec_awaddr[11:8] >= NUM_RANGES);
    assign rd_err = SLVERR_EN & (dec_araddr[11:8] >= NUM_RANGES);

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            wr_state   <= WR_IDLE;
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
            dec_awaddr <= '0;
            dec_wdata  <= '0;
            dec_wstrb  <= '0;
        end else begin
            wr_state <= wr_next;
            aw_held  <= (wr_next == WR_STROBE) ? 1'b0 : aw_held | aw_hs;
            w_held   <= (wr_next == WR_STROBE) ? 1'b0 : w_held | w_hs;
            if (aw_hs) dec_awaddr <= s_axi.S_AXI_AWADDR;
            if (w_hs) begin
                dec_wdata <= s_axi.S_AXI_WDATA;
                dec_wstrb <= s_axi.S_AXI_WSTRB;
            end
        end
    end

    // The strobe fires as soon as both halves are in, whichever arrived last.
    always_comb begin
        wr_next = wr_state;
        case (wr_state)
            WR_IDLE:   if ((aw_held | aw_hs) & (w_held | w_hs)) wr_next = WR_STROBE;
            WR_STROBE: wr_next = WR_RESP;
            WR_RESP:   if (s_axi.S_AXI_BREADY) wr_next = WR_IDLE;
            default:   wr_next = WR_IDLE;
        endcase
        slv_reg_wren       = wr_state == WR_STROBE;
        s_axi.S_AXI_BVALID = wr_state == WR_RESP;
        s_axi.S_AXI_BRESP  = (wr_state == WR_RESP && wr_err) ? 2'b10 : 2'b00;
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            rd_state   <= RD_IDLE;
            dec_araddr <= '0;
        end else begin
            rd_state <= rd_next;
            if (ar_hs) dec_araddr <= s_axi.S_AXI_ARADDR;
        end
    end

    // dec_rdata is only stable while no new rden is issued, which RD_DATA guarantees.
    always_comb begin
        rd_next = rd_state;
        case (rd_state)
            RD_IDLE:   if (ar_hs) rd_next = RD_STROBE;
            RD_STROBE: rd_next = RD_DATA;
            RD_DATA:   if (s_axi.S_AXI_RREADY) rd_next = RD_IDLE;
            default:   rd_next = RD_IDLE;
        endcase
        slv_reg_rden       = rd_state == RD_STROBE;
        s_axi.S_AXI_RVALID = rd_state == RD_DATA;
        s_axi.S_AXI_RDATA  = (rd_state == RD_DATA) ? dec_rdata : '0;
        s_axi.S_AXI_RRESP  = (rd_state == RD_DATA && rd_err) ? 2'b10 : 2'b00;
    end
endmodule

// File: tb/tb_axi_lite_slave_fe.sv
// tb_axi_lite_slave_fe: randomized AXI4-Lite transactions against a register-map model with timing checks.
module tb_axi_lite_slave_fe;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam logic [3:0] NR = 4'd5;
`ifdef AXI_SLVERR_EN
    localparam bit SLV = 1'b1;
`else
    localparam bit SLV = 1'b0;
`endif

    logic            S_AXI_ACLK = 1'b0;
    logic            S_AXI_ARESETN = 1'b0;
    logic [AW-1:0]   dec_awaddr, dec_araddr;
    logic [DW-1:0]   dec_wdata;
    logic [DW-1:0]   dec_rdata = '0;
    logic [DW/8-1:0] dec_wstrb;
    logic            slv_reg_wren, slv_reg_rden;
    logic [31:0]     dec_mem [1024];
    logic [31:0]     exp_mem [1024];
    int              checks = 0;
    int              failures = 0;
    time             t_wren, t_rden;

    axi_lite_slave_fe_if #(.C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW)) axi ();

    axi_lite_slave_fe #(.C_S_AXI_DATA_WIDTH(DW), .C_S_AXI_ADDR_WIDTH(AW), .C_NUM_RANGES(5)) dut (
        .S_AXI_ACLK(S_AXI_ACLK),
        .S_AXI_ARESETN(S_AXI_ARESETN),
        .s_axi(axi),
        .dec_awaddr(dec_awaddr),
        .dec_wdata(dec_wdata),
        .dec_wstrb(dec_wstrb),
        .dec_araddr(dec_araddr),
        .slv_reg_wren(slv_reg_wren),
        .slv_reg_rden(slv_reg_rden),
        .dec_rdata(dec_rdata)
    );

    always #5 S_AXI_ACLK = ~S_AXI_ACLK;

    // Range decoder stand-in: unmapped ranges ignore writes and read as zero.
    always @(posedge S_AXI_ACLK) begin
        if (slv_reg_wren && dec_awaddr[11:8] < NR)
            for (int b = 0; b < 4; b++)
                if (dec_wstrb[b]) dec_mem[dec_awaddr[11:2]][8*b +: 8] <= dec_wdata[8*b +: 8];
        if (slv_reg_rden) dec_rdata <= (dec_araddr[11:8] < NR) ? dec_mem[dec_araddr[11:2]] : 32'h0;
    end

    task automatic clear_inputs;
        axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WVALID  = 1'b0;
        axi.S_AXI_BREADY  = 1'b0;
        axi.S_AXI_ARVALID = 1'b0;
        axi.S_AXI_RREADY  = 1'b0;
    endtask

    task automatic reset_pulse;
        @(negedge S_AXI_ACLK);
        #2 S_AXI_ARESETN = 1'b0;
        clear_inputs();
        @(negedge S_AXI_ACLK);
        #2 S_AXI_ARESETN = 1'b1;
        @(negedge S_AXI_ACLK);
    endtask

    task automatic write_txn(input logic [11:0] a, input logic [31:0] d, input logic [3:0] st,
                             input int aw_dly, input int w_dly, input int b_dly);
        logic [1:0] er = (SLV && a[11:8] >= NR) ? 2'b10 : 2'b00;
        int hs = -1, wr_n = 0, wr_c = -1, b_c = -1;
        bit aw_d = 0, w_d = 0, b_d = 0;
        if (a[11:8] < NR)
            for (int b = 0; b < 4; b++) if (st[b]) exp_mem[a[11:2]][8*b +: 8] = d[8*b +: 8];
        for (int c = 0; c < 60 && !b_d; c++) begin
            @(negedge S_AXI_ACLK);
            if (slv_reg_wren) begin
                wr_n++; wr_c = c; t_wren = $time;
                checks++;
                if (dec_awaddr !== a || dec_wdata !== d || dec_wstrb !== st) begin
                    failures++;
                    $display("FAIL wr_latch got=%h/%h/%h exp=%h/%h/%h", dec_awaddr, dec_wdata, dec_wstrb, a, d, st);
                end
            end
            if (b_c >= 0 && !axi.S_AXI_BVALID) begin
                checks++; failures++;
                $display("FAIL bvalid_drop got=0 exp=1");
            end
            if (axi.S_AXI_BVALID && b_c < 0) b_c = c;
            if (w_d && !aw_d) begin
                checks++;
                if (axi.S_AXI_WREADY !== 1'b0) begin
                    failures++;
                    $display("FAIL wready_held got=%b exp=0", axi.S_AXI_WREADY);
                end
            end
            axi.S_AXI_AWVALID = !aw_d && c >= aw_dly;
            axi.S_AXI_AWADDR  = aw_d ? ~a : a;
            axi.S_AXI_WVALID  = !w_d && c >= w_dly;
            axi.S_AXI_WDATA   = w_d ? ~d : d;
            axi.S_AXI_WSTRB   = w_d ? ~st : st;
            axi.S_AXI_BREADY  = (b_dly == 0) || (b_c >= 0 && c >= b_c + b_dly);
            if (axi.S_AXI_AWVALID && axi.S_AXI_AWREADY) begin aw_d = 1; hs = c; end
            if (axi.S_AXI_WVALID && axi.S_AXI_WREADY) begin w_d = 1; hs = c; end
            if (axi.S_AXI_BVALID && axi.S_AXI_BREADY) begin
                b_d = 1;
                checks++;
                if (axi.S_AXI_BRESP !== er) begin
                    failures++;
                    $display("FAIL bresp addr=%h got=%b exp=%b", a, axi.S_AXI_BRESP, er);
                end
            end
        end
        @(negedge S_AXI_ACLK);
        axi.S_AXI_BREADY = 1'b0;
        checks++;
        if (!b_d || wr_n != 1 || wr_c != hs + 1 || b_c != hs + 2) begin
            failures++;
            $display("FAIL wr_timing done=%0d wren_n=%0d wren_c=%0d b_c=%0d exp=1/1/%0d/%0d", b_d, wr_n, wr_c, b_c, hs + 1, hs + 2);
        end
        checks++;
        if (axi.S_AXI_BVALID !== 1'b0 || axi.S_AXI_AWREADY !== 1'b1) begin
            failures++;
            $display("FAIL wr_after bvalid=%b awready=%b exp=0/1", axi.S_AXI_BVALID, axi.S_AXI_AWREADY);
        end
    endtask

    task automatic read_txn(input logic [11:0] a, input int r_dly);
        logic [31:0] ed = (a[11:8] < NR) ? exp_mem[a[11:2]] : 32'h0;
        logic [1:0]  er = (SLV && a[11:8] >= NR) ? 2'b10 : 2'b00;
        int hs = -1, rd_n = 0, rd_c = -1, r_c = -1;
        bit ar_d = 0, r_d = 0;
        for (int c = 0; c < 60 && !r_d; c++) begin
            @(negedge S_AXI_ACLK);
            if (slv_reg_rden) begin
                rd_n++; rd_c = c; t_rden = $time;
                checks++;
                if (dec_araddr !== a) begin
                    failures++;
                    $display("FAIL rd_latch got=%h exp=%h", dec_araddr, a);
                end
            end
            if (r_c >= 0 && !axi.S_AXI_RVALID) begin
                checks++; failures++;
                $display("FAIL rvalid_drop got=0 exp=1");
            end
            if (axi.S_AXI_RVALID && r_c < 0) r_c = c;
            if (ar_d) begin
                checks++;
                if (axi.S_AXI_ARREADY !== 1'b0) begin
                    failures++;
                    $display("FAIL arready_busy got=%b exp=0", axi.S_AXI_ARREADY);
                end
            end
            if (axi.S_AXI_RVALID) begin
                checks++;
                if (axi.S_AXI_RDATA !== ed) begin
                    failures++;
                    $display("FAIL rdata addr=%h got=%h exp=%h", a, axi.S_AXI_RDATA, ed);
                end
            end
            axi.S_AXI_ARVALID = !ar_d;
            axi.S_AXI_ARADDR  = ar_d ? ~a : a;
            axi.S_AXI_RREADY  = (r_dly == 0) || (r_c >= 0 && c >= r_c + r_dly);
            if (axi.S_AXI_ARVALID && axi.S_AXI_ARREADY) begin ar_d = 1; hs = c; end
            if (axi.S_AXI_RVALID && axi.S_AXI_RREADY) begin
                r_d = 1;
                checks++;
                if (axi.S_AXI_RRESP !== er) begin
                    failures++;
                    $display("FAIL rresp addr=%h got=%b exp=%b", a, axi.S_AXI_RRESP, er);
                end
            end
        end
        @(negedge S_AXI_ACLK);
        axi.S_AXI_RREADY = 1'b0;
        checks++;
        if (!r_d || rd_n != 1 || rd_c != hs + 1 || r_c != hs + 2 || axi.S_AXI_RVALID !== 1'b0) begin
            failures++;
            $display("FAIL rd_timing done=%0d rden_n=%0d rden_c=%0d r_c=%0d rvalid=%b exp=1/1/%0d/%0d/0", r_d, rd_n, rd_c, r_c, axi.S_AXI_RVALID, hs + 1, hs + 2);
        end
    endtask

    task automatic test_reset;
        repeat (2) @(negedge S_AXI_ACLK);
        checks++;
        if ({axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_BVALID, axi.S_AXI_BRESP, axi.S_AXI_ARREADY,
             axi.S_AXI_RVALID, axi.S_AXI_RRESP, axi.S_AXI_RDATA, dec_awaddr, dec_wdata, dec_wstrb,
             dec_araddr, slv_reg_wren, slv_reg_rden} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=nonzero exp=0");
        end
        #2 S_AXI_ARESETN = 1'b1;
        #1;
        checks++;
        if ({axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY} !== 3'b000) begin
            failures++;
            $display("FAIL ready_after_release got=%b%b%b exp=000", axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY);
        end
        @(negedge S_AXI_ACLK);
        checks++;
        if ({axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY} !== 3'b111) begin
            failures++;
            $display("FAIL ready_init_done got=%b%b%b exp=111", axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY);
        end
    endtask

    task automatic test_write_same_cycle;
        write_txn(12'h104, 32'hA5A5_0001, 4'hF, 0, 0, 0);
        read_txn(12'h104, 0);
    endtask

    task automatic test_w_before_aw;
        write_txn(12'h200, 32'hC0DE_0200, 4'hF, 3, 0, 1);
        read_txn(12'h200, 1);
    endtask

    task automatic test_read_backpressure;
        write_txn(12'h300, 32'h1234_5678, 4'hF, 0, 0, 0);
        read_txn(12'h300, 4);
    endtask

    task automatic test_concurrent;
        write_txn(12'h100, 32'h0100_BEEF, 4'hF, 0, 0, 0);
        fork
            write_txn(12'h000, 32'h0000_CAFE, 4'hF, 0, 0, 0);
            read_txn(12'h100, 0);
        join
        checks++;
        if (t_wren != t_rden) begin
            failures++;
            $display("FAIL concurrent_strobes wren_t=%0t rden_t=%0t exp=equal", t_wren, t_rden);
        end
        read_txn(12'h000, 0);
        read_txn(12'h100, 0);
    endtask

    task automatic test_reset_mid;
        int n = 0;
        @(negedge S_AXI_ACLK);
        axi.S_AXI_AWADDR = 12'h010; axi.S_AXI_AWVALID = 1'b1;
        axi.S_AXI_WDATA = 32'hDEAD_BEEF; axi.S_AXI_WSTRB = 4'hF; axi.S_AXI_WVALID = 1'b1;
        axi.S_AXI_BREADY = 1'b0;
        exp_mem[12'h010 >> 2] = 32'hDEAD_BEEF;
        @(negedge S_AXI_ACLK);
        axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0;
        while (!axi.S_AXI_BVALID && n < 8) begin @(negedge S_AXI_ACLK); n++; end
        checks++;
        if (axi.S_AXI_BVALID !== 1'b1) begin
            failures++;
            $display("FAIL mid_bvalid got=%b exp=1", axi.S_AXI_BVALID);
        end
        #2 S_AXI_ARESETN = 1'b0;
        #1;
        checks++;
        if ({axi.S_AXI_BVALID, axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY} !== 4'b0000) begin
            failures++;
            $display("FAIL async_reset got=%b%b%b%b exp=0000", axi.S_AXI_BVALID, axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY);
        end
        @(negedge S_AXI_ACLK);
        #2 S_AXI_ARESETN = 1'b1;
        #1;
        checks++;
        if ({axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY} !== 3'b000) begin
            failures++;
            $display("FAIL mid_ready_release got=%b%b%b exp=000", axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY);
        end
        @(negedge S_AXI_ACLK);
        axi.S_AXI_AWADDR = 12'h020; axi.S_AXI_AWVALID = 1'b1;
        @(negedge S_AXI_ACLK);
        axi.S_AXI_AWVALID = 1'b0;
        checks++;
        if (axi.S_AXI_AWREADY !== 1'b0 || axi.S_AXI_WREADY !== 1'b1) begin
            failures++;
            $display("FAIL aw_held awready=%b wready=%b exp=0/1", axi.S_AXI_AWREADY, axi.S_AXI_WREADY);
        end
        reset_pulse();
        axi.S_AXI_WDATA = 32'h0BAD_0BAD; axi.S_AXI_WVALID = 1'b1;
        @(negedge S_AXI_ACLK);
        axi.S_AXI_WVALID = 1'b0;
        repeat (4) begin
            @(negedge S_AXI_ACLK);
            checks++;
            if (slv_reg_wren !== 1'b0 || axi.S_AXI_AWREADY !== 1'b1 || axi.S_AXI_WREADY !== 1'b0) begin
                failures++;
                $display("FAIL discarded_write wren=%b awready=%b wready=%b exp=0/1/0", slv_reg_wren, axi.S_AXI_AWREADY, axi.S_AXI_WREADY);
            end
        end
        reset_pulse();
        write_txn(12'h014, 32'h5555_AAAA, 4'hF, 0, 0, 0);
        read_txn(12'h010, 0);
        read_txn(12'h014, 0);
    endtask

    task automatic test_slverr;
        write_txn(12'h700, 32'hFFFF_FFFF, 4'hF, 0, 0, 0);
        read_txn(12'h700, 0);
        write_txn(12'h4FC, 32'h0BAD_F00D, 4'hF, 1, 0, 0);
        read_txn(12'h4FC, 0);
    endtask

    task automatic test_random;
        for (int i = 0; i < 25; i++) begin
            logic [11:0] a = {4'($urandom_range(0, 4)), 6'($urandom), 2'b00};
            write_txn(a, $urandom, 4'($urandom_range(1, 15)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            read_txn(a, $urandom_range(0, 2));
            read_txn({4'($urandom_range(0, 7)), 6'($urandom), 2'b00}, $urandom_range(0, 3));
        end
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 4; i++) write_txn(12'h040 + 12'(4 * i), 32'h1111_0000 + i, 4'hF, 0, 0, 0);
        for (int i = 0; i < 4; i++) read_txn(12'h040 + 12'(4 * i), 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) begin dec_mem[i] = '0; exp_mem[i] = '0; end
        axi.S_AXI_AWADDR = '0; axi.S_AXI_WDATA = '0; axi.S_AXI_WSTRB = '0; axi.S_AXI_ARADDR = '0;
        clear_inputs();
        test_reset();
        test_write_same_cycle();
        test_w_before_aw();
        test_read_backpressure();
        test_concurrent();
        test_reset_mid();
        test_slverr();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
